// File: rtl/fan_ctrl_pkg.sv
// Shared widths and the temperature-to-duty curve for the multi-channel fan controller.
package fan_ctrl_pkg;

    localparam int DUTY_W = 8;
    localparam int TACH_W = 16;

    // Piecewise-linear curve: flat below t_lo, full above t_hi, linear ramp between.
    function automatic logic [15:0] fan_curve(
        input logic [7:0]  temp,
        input logic [15:0] duty_min,
        input logic [15:0] period,
        input logic [7:0]  t_lo,
        input logic [7:0]  t_hi,
        input logic [15:0] slope
    );
        logic [15:0] v;
        if (temp <= t_lo) begin
            v = duty_min;
        end else if (temp >= t_hi) begin
            v = period;
        end else begin
            v = duty_min + 16'(temp - t_lo) * slope;
            if (v > period) v = period;
        end
        return v;
    endfunction

endpackage

// File: rtl/fan_tach_chan.sv
// One fan's tach path: synchroniser, falling-edge counter, per-window latch and sticky stall flag.
module fan_tach_chan
    import fan_ctrl_pkg::*;
#(
    parameter int STALL_MIN = 2
) (
    input  logic              clk0,
    input  logic              rstn,
    input  logic              tach_in,
    input  logic              win_end,
    input  logic              chk_en,
    input  logic              fault_clr,
    output logic [TACH_W-1:0] tach_cnt,
    output logic              fan_fault
);

    logic [1:0]        r_sync;
    logic              r_last;
    logic [TACH_W-1:0] r_cnt;
    logic              w_edge;
    logic              w_stall;

    assign w_edge  = r_last & ~r_sync[1];
    assign w_stall = win_end & chk_en & (r_cnt < TACH_W'(STALL_MIN));

    always_ff @(posedge clk0 or negedge rstn) begin
        if (!rstn) begin
            r_sync    <= 2'b00;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            tach_cnt  <= '0;
            fan_fault <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], tach_in};
            r_last <= r_sync[1];
            // An edge landing on the window's last cycle belongs to the next window.
            if (win_end) begin
                tach_cnt <= r_cnt;
                r_cnt    <= w_edge ? TACH_W'(1) : '0;
            end else if (w_edge && (r_cnt != '1)) begin
                r_cnt <= r_cnt + TACH_W'(1);
            end
            if (w_stall)        fan_fault <= 1'b1;
            else if (fault_clr) fan_fault <= 1'b0;
        end
    end

endmodule

// File: rtl/fan_ctrl_mc.sv
// Multi-channel PWM fan controller: temperature curve, slew-limited duty, manual override, tach stall guard.
module fan_ctrl_mc
    import fan_ctrl_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int PERIOD     = 222,
    parameter int DUTY_INIT  = 150,
    parameter int DUTY_MIN   = 60,
    parameter int T_LO       = 40,
    parameter int T_HI       = 80,
    parameter int SLOPE      = 4,
    parameter int SLEW       = 8,
    parameter int TACH_WIN   = 7812500,
    parameter int STALL_MIN  = 2,
    parameter int SPINUP_WIN = 2
) (
    input  logic                    clk0,
    input  logic                    rstn,
    input  logic                    temp_valid,
    input  logic [7:0]              temp_data,
    input  logic [NCH-1:0]          man_en,
    input  logic [NCH*DUTY_W-1:0]   man_duty,
    input  logic [NCH-1:0]          tach_in,
    input  logic                    fault_clr,
    output logic [NCH-1:0]          pwm_out,
    output logic [NCH*DUTY_W-1:0]   duty_cur,
    output logic [NCH*TACH_W-1:0]   tach_cnt,
    output logic                    tach_valid,
    output logic [NCH-1:0]          fan_fault
);

    localparam logic [15:0]       P16      = 16'(PERIOD);
    localparam logic [DUTY_W-1:0] P8       = DUTY_W'(PERIOD);
    localparam logic [15:0]       S16      = 16'(SLEW);
    localparam logic [15:0]       CNT_LAST = 16'(PERIOD - 1);
    localparam logic [31:0]       WIN_LAST = 32'(TACH_WIN - 1);
    localparam logic [7:0]        SPIN_N   = 8'(SPINUP_WIN);

    logic [7:0]  r_temp;
    logic [15:0] r_pwm_cnt;
    logic [31:0] r_win_cnt;
    logic [7:0]  r_spin_cnt;
    logic        r_tach_valid;
    logic [15:0] w_curve;
    logic        w_bound;
    logic        w_win_end;
    logic        w_chk_en;

    assign w_curve   = fan_curve(r_temp, 16'(DUTY_MIN), P16, 8'(T_LO), 8'(T_HI), 16'(SLOPE));
    assign w_bound   = (r_pwm_cnt == CNT_LAST);
    assign w_win_end = (r_win_cnt == WIN_LAST);
    assign w_chk_en  = (r_spin_cnt >= SPIN_N);
    assign tach_valid = r_tach_valid;

    always_ff @(posedge clk0 or negedge rstn) begin
        if (!rstn) begin
            r_temp       <= '0;
            r_pwm_cnt    <= '0;
            r_win_cnt    <= '0;
            r_spin_cnt   <= '0;
            r_tach_valid <= 1'b0;
        end else begin
            if (temp_valid) r_temp <= temp_data;
            r_pwm_cnt    <= w_bound ? '0 : r_pwm_cnt + 16'd1;
            r_win_cnt    <= w_win_end ? '0 : r_win_cnt + 32'd1;
            r_tach_valid <= w_win_end;
            // Spin-up counter saturates once the stall check is armed.
            if (w_win_end && !w_chk_en) r_spin_cnt <= r_spin_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DUTY_W-1:0] r_duty;
        logic              r_pwm;
        logic [DUTY_W-1:0] w_man;
        logic [15:0]       w_cur;
        logic [15:0]       w_tgt;
        logic [15:0]       w_nxt;

        assign w_man = man_duty[DUTY_W*g +: DUTY_W];

        always_comb begin
            w_cur = 16'(r_duty);
            if (fan_fault[g])   w_tgt = P16;
            else if (man_en[g]) w_tgt = (w_man > P8) ? P16 : 16'(w_man);
            else                w_tgt = w_curve;
            if (fan_fault[g])       w_nxt = P16;
            else if (w_tgt > w_cur) w_nxt = ((w_tgt - w_cur) > S16) ? w_cur + S16 : w_tgt;
            else                    w_nxt = ((w_cur - w_tgt) > S16) ? w_cur - S16 : w_tgt;
        end

        always_ff @(posedge clk0 or negedge rstn) begin
            if (!rstn) begin
                r_duty <= DUTY_W'(DUTY_INIT);
                r_pwm  <= 1'b0;
            end else begin
                if (w_bound) r_duty <= DUTY_W'(w_nxt);
                r_pwm <= (r_pwm_cnt < w_cur);
            end
        end

        assign duty_cur[DUTY_W*g +: DUTY_W] = r_duty;
        assign pwm_out[g]                   = r_pwm;

        fan_tach_chan #(
            .STALL_MIN (STALL_MIN)
        ) u_tach (
            .clk0      (clk0),
            .rstn      (rstn),
            .tach_in   (tach_in[g]),
            .win_end   (w_win_end),
            .chk_en    (w_chk_en),
            .fault_clr (fault_clr),
            .tach_cnt  (tach_cnt[TACH_W*g +: TACH_W]),
            .fan_fault (fan_fault[g])
        );
    end

endmodule
